// File: rtl/enemy_array_pkg.sv
// Shared widths, hit-FSM state encoding and a width helper for the enemy array.
package enemy_array_pkg;

    localparam int COORD_W = 12;
    localparam int SPD_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIT  = 2'd1,
        ST_COOL = 2'd2
    } hit_state_t;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        if (res == 0) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/enemy_array_mover.sv
// One bouncing enemy square: moves along a single axis, clamps to the playfield and
// reverses direction on reaching either limit; box edges derive from the registered centre.
module enemy_array_mover
    import enemy_array_pkg::*;
#(
    parameter int                 H_SIZE   = 20,
    parameter int                 D_WIDTH  = 640,
    parameter int                 D_HEIGHT = 480,
    parameter logic [COORD_W-1:0] INIT_X   = 12'd150,
    parameter logic [COORD_W-1:0] INIT_Y   = 12'd150,
    parameter logic [SPD_W-1:0]   SPEED    = 6'd10,
    parameter bit                 AXIS     = 1'b0,
    parameter bit                 INIT_DIR = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_restart,
    input  logic               i_move,
    output logic [COORD_W-1:0] o_x1,
    output logic [COORD_W-1:0] o_x2,
    output logic [COORD_W-1:0] o_y1,
    output logic [COORD_W-1:0] o_y2
);

    localparam int                 P_MIN  = H_SIZE + 1;
    localparam int                 P_MAX  = AXIS ? (D_WIDTH - H_SIZE - 1) : (D_HEIGHT - H_SIZE - 1);
    localparam logic [COORD_W-1:0] P_INIT = AXIS ? INIT_X : INIT_Y;

    logic [COORD_W-1:0] p_q, p_d;
    logic               dir_q, dir_d;
    logic [COORD_W:0]   up_sum;
    logic [COORD_W:0]   lo_lim;
    logic [COORD_W-1:0] cx, cy;

    // Comparisons are done one bit wider so p+s can never wrap past the limit.
    always_comb begin
        p_d    = p_q;
        dir_d  = dir_q;
        up_sum = {1'b0, p_q} + (COORD_W+1)'(SPEED);
        lo_lim = (COORD_W+1)'(P_MIN) + (COORD_W+1)'(SPEED);
        if (i_move && (SPEED != '0)) begin
            if (dir_q) begin
                if (up_sum >= (COORD_W+1)'(P_MAX)) begin
                    p_d   = COORD_W'(P_MAX);
                    dir_d = 1'b0;
                end else begin
                    p_d = up_sum[COORD_W-1:0];
                end
            end else begin
                if ({1'b0, p_q} <= lo_lim) begin
                    p_d   = COORD_W'(P_MIN);
                    dir_d = 1'b1;
                end else begin
                    p_d = p_q - COORD_W'(SPEED);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            p_q   <= P_INIT;
            dir_q <= INIT_DIR;
        end else begin
            p_q   <= p_d;
            dir_q <= dir_d;
        end
    end

    assign cx   = AXIS ? p_q : INIT_X;
    assign cy   = AXIS ? INIT_Y : p_q;
    assign o_x1 = cx - COORD_W'(H_SIZE);
    assign o_x2 = cx + COORD_W'(H_SIZE);
    assign o_y1 = cy - COORD_W'(H_SIZE);
    assign o_y2 = cy + COORD_W'(H_SIZE);

endmodule

// File: rtl/enemy_array.sv
// N bouncing enemies with pixel hit-test, registered player-collision vector and a
// hit/cooldown FSM producing a single-cycle hit pulse and a saturating hit count.
module enemy_array
    import enemy_array_pkg::*;
#(
    parameter int                   N        = 3,
    parameter int                   H_SIZE   = 20,
    parameter int                   D_WIDTH  = 640,
    parameter int                   D_HEIGHT = 480,
    parameter logic [N*COORD_W-1:0] INIT_X   = {12'd400, 12'd275, 12'd150},
    parameter logic [N*COORD_W-1:0] INIT_Y   = {12'd400, 12'd275, 12'd150},
    parameter logic [N*SPD_W-1:0]   SPEED    = {6'd20, 6'd15, 6'd10},
    parameter logic [N-1:0]         AXIS     = '0,
    parameter logic [N-1:0]         INIT_DIR = '1,
    parameter int                   COOLDOWN = 60
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_ani_stb,
    input  logic                   i_animate,
    input  logic                   i_en,
    input  logic                   i_restart,
    input  logic [COORD_W-1:0]     i_px1,
    input  logic [COORD_W-1:0]     i_px2,
    input  logic [COORD_W-1:0]     i_py1,
    input  logic [COORD_W-1:0]     i_py2,
    input  logic [9:0]             i_x,
    input  logic [8:0]             i_y,
    output logic [N*COORD_W-1:0]   o_x1,
    output logic [N*COORD_W-1:0]   o_x2,
    output logic [N*COORD_W-1:0]   o_y1,
    output logic [N*COORD_W-1:0]   o_y2,
    output logic                   o_pix,
    output logic                   o_hit,
    output logic [2:0]             o_hit_id,
    output logic [3:0]             o_hits,
    output logic                   o_immune
);

    localparam int CNT_W = clog2(COOLDOWN + 1);

    logic             frame_tick;
    logic [N-1:0]     ov_d, ov_q;
    logic [N-1:0]     pix_vec;
    logic [2:0]       low_id;
    logic [COORD_W-1:0] px_ext, py_ext;

    hit_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       hit_id_q, hit_id_d;
    logic [3:0]       hits_q, hits_d;

    assign frame_tick = i_animate & i_ani_stb;
    assign px_ext     = COORD_W'(i_x);
    assign py_ext     = COORD_W'(i_y);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            enemy_array_mover #(
                .H_SIZE   (H_SIZE),
                .D_WIDTH  (D_WIDTH),
                .D_HEIGHT (D_HEIGHT),
                .INIT_X   (INIT_X[gi*COORD_W +: COORD_W]),
                .INIT_Y   (INIT_Y[gi*COORD_W +: COORD_W]),
                .SPEED    (SPEED[gi*SPD_W +: SPD_W]),
                .AXIS     (AXIS[gi]),
                .INIT_DIR (INIT_DIR[gi])
            ) u_mover (
                .i_clk     (i_clk),
                .i_rst     (i_rst),
                .i_restart (i_restart),
                .i_move    (frame_tick & i_en),
                .o_x1      (o_x1[gi*COORD_W +: COORD_W]),
                .o_x2      (o_x2[gi*COORD_W +: COORD_W]),
                .o_y1      (o_y1[gi*COORD_W +: COORD_W]),
                .o_y2      (o_y2[gi*COORD_W +: COORD_W])
            );

            // Strict inequalities: boxes that merely share an edge do not collide.
            assign ov_d[gi] = (i_px1 < o_x2[gi*COORD_W +: COORD_W]) &&
                              (o_x1[gi*COORD_W +: COORD_W] < i_px2) &&
                              (i_py1 < o_y2[gi*COORD_W +: COORD_W]) &&
                              (o_y1[gi*COORD_W +: COORD_W] < i_py2);

            assign pix_vec[gi] = (o_x1[gi*COORD_W +: COORD_W] < px_ext) &&
                                 (px_ext < o_x2[gi*COORD_W +: COORD_W]) &&
                                 (o_y1[gi*COORD_W +: COORD_W] < py_ext) &&
                                 (py_ext < o_y2[gi*COORD_W +: COORD_W]);
        end
    endgenerate

    assign o_pix = |pix_vec;

    always_comb begin
        low_id = 3'd0;
        for (int k = N - 1; k >= 0; k--) begin
            if (ov_q[k]) begin
                low_id = 3'(k);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hit_id_d = hit_id_q;
        hits_d   = hits_q;
        case (state_q)
            ST_IDLE: begin
                if (|ov_q) begin
                    state_d  = ST_HIT;
                    hit_id_d = low_id;
                    hits_d   = (hits_q == 4'd15) ? hits_q : hits_q + 4'd1;
                    cnt_d    = CNT_W'(COOLDOWN);
                end
            end
            ST_HIT: begin
                state_d = ST_COOL;
            end
            ST_COOL: begin
                if (frame_tick) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Soft restart keeps the score-like outputs (count and last id).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hit_id_q <= 3'd0;
            hits_q   <= 4'd0;
            ov_q     <= '0;
        end else if (i_restart) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ov_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hit_id_q <= hit_id_d;
            hits_q   <= hits_d;
            ov_q     <= ov_d;
        end
    end

    assign o_hit    = (state_q == ST_HIT) && !i_rst;
    assign o_hit_id = hit_id_q;
    assign o_hits   = hits_q;
    assign o_immune = (state_q == ST_COOL);

endmodule
